fdiv: RTL

FDIV -- requirements
Module: fdiv

---
 rtl/fp_pkg.sv | 16 +
 rtl/fp_classify.sv | 24 ++
 rtl/fdiv.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 constants and the fdiv state encoding.
package fp_pkg;

  localparam int unsigned FP_EXP_BIAS = 127;
  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF  = 32'h7F800000;
  localparam int unsigned FDIV_ITERS  = 26;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ROUND,
    DONE
  } fdiv_state_e;

endpackage

// File: rtl/fp_classify.sv
// Classifies a binary32 operand; subnormals are reported as zero (flush-to-zero).
module fp_classify (
  input  logic [31:0] x,
  output logic        sign,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_norm
);

  logic [7:0] exp_f;
  logic       man_nz;

  always_comb begin
    exp_f   = x[30:23];
    man_nz  = |x[22:0];
    sign    = x[31];
    is_zero = (exp_f == 8'h00);
    is_inf  = (exp_f == 8'hFF) && !man_nz;
    is_nan  = (exp_f == 8'hFF) && man_nz;
    is_norm = (exp_f != 8'h00) && (exp_f != 8'hFF);
  end

endmodule

// File: rtl/fdiv.sv
// binary32 divider: restoring division, one quotient bit per cycle, RNE rounding.
module fdiv
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);

  fdiv_state_e state_q, state_d;

  logic [24:0]       rem_q;
  logic [25:0]       quo_q;
  logic signed [9:0] exp_q;
  logic              sign_q;
  logic [4:0]        cnt_q;
  logic [31:0]       result_q;
  logic [22:0]       b_man_q;

  logic a_sign, a_zero, a_inf, a_nan, a_norm;
  logic b_sign, b_zero, b_inf, b_nan, b_norm;
  logic accept, special, last_iter;
  logic [31:0] spec_res;

  fp_classify u_cls_a (
    .x       (a),
    .sign    (a_sign),
    .is_zero (a_zero),
    .is_inf  (a_inf),
    .is_nan  (a_nan),
    .is_norm (a_norm)
  );

  fp_classify u_cls_b (
    .x       (b),
    .sign    (b_sign),
    .is_zero (b_zero),
    .is_inf  (b_inf),
    .is_nan  (b_nan),
    .is_norm (b_norm)
  );

  assign accept    = in_valid & in_ready;
  assign special   = !(a_norm & b_norm);
  assign last_iter = (cnt_q == 5'(FDIV_ITERS - 1));
  assign out       = result_q;

  always_comb begin
    if (a_nan || b_nan) begin
      spec_res = FP_QNAN;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_res = FP_QNAN;
    end else if (a_inf || b_zero) begin
      spec_res = {a_sign ^ b_sign, FP_POS_INF[30:0]};
    end else begin
      spec_res = {a_sign ^ b_sign, 31'd0};
    end
  end

  // One restoring step: subtract the divisor when it fits, then shift.
  logic [23:0] divisor;
  logic        rem_ge;
  logic [23:0] rem_sub;

  always_comb begin
    divisor = {1'b1, b_man_q};
    rem_ge  = (rem_q >= {1'b0, divisor});
    rem_sub = rem_ge ? 24'(rem_q - {1'b0, divisor}) : rem_q[23:0];
  end

  logic              q_norm, guard, sticky;
  logic [23:0]       mant;
  logic [24:0]       mant_rnd;
  logic signed [9:0] exp_adj, exp_fin;
  logic [22:0]       frac;
  logic [31:0]       round_res;

  always_comb begin
    q_norm   = quo_q[25];
    mant     = q_norm ? quo_q[25:2] : quo_q[24:1];
    guard    = q_norm ? quo_q[1] : quo_q[0];
    sticky   = (q_norm & quo_q[0]) | (|rem_q);
    exp_adj  = q_norm ? exp_q : exp_q - 10'sd1;
    mant_rnd = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    exp_fin  = mant_rnd[24] ? exp_adj + 10'sd1 : exp_adj;
    frac     = mant_rnd[24] ? mant_rnd[23:1] : mant_rnd[22:0];
    if (exp_fin >= 10'sd255) begin
      round_res = {sign_q, FP_POS_INF[30:0]};
    end else if (exp_fin <= 10'sd0) begin
      round_res = {sign_q, 31'd0};
    end else begin
      round_res = {sign_q, exp_fin[7:0], frac};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : CALC;
      CALC:    if (last_iter) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      b_man_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q <= '0;
            if (special) begin
              result_q <= spec_res;
            end else begin
              rem_q   <= {2'b01, a[22:0]};
              quo_q   <= '0;
              exp_q   <= {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'(FP_EXP_BIAS);
              sign_q  <= a_sign ^ b_sign;
              b_man_q <= b[22:0];
            end
          end
        end
        CALC: begin
          rem_q <= {rem_sub, 1'b0};
          quo_q <= {quo_q[24:0], rem_ge};
          cnt_q <= cnt_q + 5'd1;
        end
        ROUND:   result_q <= round_res;
        DONE:    ;
        default: ;
      endcase
    end
  end

endmodule
